// File: rtl/riscv_pkg.sv
// ============================================================================
// Module  : riscv_pkg
// Brief   : Shared fetch constants, widths and state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int PC_W_DEF = 8;
  localparam int INSTR_W  = 32;
  localparam int PC_STEP  = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_RUN   = 2'd1;
  localparam fetch_state_t ST_FAULT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/fetch_out_reg.sv
// ============================================================================
// Module  : fetch_out_reg
// Brief   : Single-entry valid/ready output register (instr, pc, valid).
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_out_reg
  import riscv_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               load,
  input  logic               ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc
);

  logic               valid_d, valid_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [PC_W-1:0]    pc_d, pc_q;

  // Flush beats load; a consume with no new load empties the stage.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module  : inst_fetch
// Brief   : PC sequencer with redirect and a valid/ready output stage.
//           Optional macro MISALIGN_TRAP_EN traps misaligned redirects.
// Revision: 1.0
// ============================================================================
`default_nettype none

module inst_fetch
  import riscv_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_addr,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               fault
);

  fetch_state_t    state_d, state_q;
  logic [PC_W-1:0] pc_d, pc_q;
  logic            fault_d, fault_q;
  logic            fire;
  logic            flush;
  logic            misalign;
  logic [PC_W-1:0] redirect_tgt;

  assign redirect_tgt = {redirect_addr[PC_W-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
  assign misalign = |redirect_addr[1:0];
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^redirect_addr[1:0];
  assign misalign        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    fire    = 1'b0;
    flush   = 1'b0;
    if (state_q != ST_FAULT) begin
      state_d = fetch_en ? ST_RUN : ST_IDLE;
      if (redirect_valid) begin
        flush = 1'b1;
        if (misalign) begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          pc_d = redirect_tgt;
        end
      end else begin
        fire = fetch_en && (!out_valid || out_ready);
        if (fire) begin
          pc_d = pc_q + PC_W'(PC_STEP);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_out_reg #(
    .PC_W (PC_W)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .load     (fire),
    .ready    (out_ready),
    .in_instr (imem_instr),
    .in_pc    (pc_q),
    .valid    (out_valid),
    .instr    (out_instr),
    .pc       (out_pc)
  );

  assign imem_addr = pc_q;
  assign fault     = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module  : tb_inst_fetch
// Brief   : Directed and randomized check of inst_fetch against a cycle model.
//           Honours MISALIGN_TRAP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        fault;

  logic [31:0] mem [64];

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0]  m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [7:0]  m_opc;
  logic        m_fault;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[7:2]];

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Next-cycle behaviour, applied to the inputs present just before the edge.
  task automatic model_update();
    logic [31:0] word;
    word = mem[m_pc[7:2]];
    if (rst) begin
      m_pc = 8'h00; m_valid = 1'b0; m_instr = '0; m_opc = '0; m_fault = 1'b0;
    end else if (m_fault) begin
      m_valid = 1'b0;
    end else if (redirect_valid) begin
      m_valid = 1'b0;
      if (TRAP && redirect_addr % 4 != 0) m_fault = 1'b1;
      else m_pc = redirect_addr - (redirect_addr % 4);
    end else if (fetch_en && (!m_valid || out_ready)) begin
      m_instr = word;
      m_opc   = m_pc;
      m_valid = 1'b1;
      m_pc    = m_pc + 8'd4;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_model();
    check("imem_addr", imem_addr, m_pc);
    check("out_valid", out_valid, m_valid);
    check("fault", fault, m_fault);
    if (m_valid) begin
      check("out_instr", out_instr, m_instr);
      check("out_pc", out_pc, m_opc);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive(input logic r, input logic en, input logic rdy,
                       input logic rv, input logic [7:0] ra);
    rst = r; fetch_en = en; out_ready = rdy; redirect_valid = rv; redirect_addr = ra;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_instr"}, out_instr, 32'h0);
    check({tag, "_pc"}, out_pc, 8'h00);
    check({tag, "_addr"}, imem_addr, 8'h00);
    check({tag, "_fault"}, fault, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_7033;
    mem[1] = 32'h0010_0093;
    m_pc = '0; m_valid = 1'b0; m_instr = '0; m_opc = '0; m_fault = 1'b0;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    step();
    check_reset_outputs("rst");

    // Basic sequential fetch.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    check("c1_pc", out_pc, 8'h00);
    check("c1_instr", out_instr, 32'h0000_7033);
    step();
    check("c2_pc", out_pc, 8'h04);
    check("c2_instr", out_instr, 32'h0010_0093);
    step();
    check("c3_pc", out_pc, 8'h08);

    // Stall for three cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", out_pc, 8'h08);
      check("stall_instr", out_instr, mem[2]);
      check("stall_addr", imem_addr, 8'h0C);
    end
    out_ready = 1'b1;
    step();
    check("release_pc", out_pc, 8'h0C);

    // Redirect while stalled.
    out_ready = 1'b0;
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h40);
    step();
    check("redir_valid", out_valid, 1'b0);
    check("redir_addr", imem_addr, 8'h40);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    step();
    check("redir_pc", out_pc, 8'h40);

    // Address wrap.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hFC);
    step();
    redirect_valid = 1'b0;
    step();
    check("wrap0", out_pc, 8'hFC);
    step();
    check("wrap1", out_pc, 8'h00);
    step();
    check("wrap2", out_pc, 8'h04);

    // Back-to-back redirects: the later one wins.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h20);
    step();
    redirect_addr = 8'h80;
    step();
    redirect_valid = 1'b0;
    step();
    check("b2b_pc", out_pc, 8'h80);

    // Reset during a stall.
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    check_reset_outputs("rst_stall");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step();
    check("no_replay", out_valid, 1'b0);

    // Misaligned redirect.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h42);
    step();
    redirect_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
    check("mis_fault", fault, 1'b1);
    check("mis_valid", out_valid, 1'b0);
    check("mis_addr", imem_addr, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      check("mis_hold", out_valid, 1'b0);
    end
`else
    check("mis_addr", imem_addr, 8'h40);
    check("mis_fault", fault, 1'b0);
    step();
    check("mis_pc", out_pc, 8'h40);
`endif
    rst = 1'b1;
    step();
    check_reset_outputs("rst_fault");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 79) == 0);
      fetch_en       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 1) == 1);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_addr  = 8'($urandom) & 8'hFC;
      if ($urandom_range(0, 5) == 0) redirect_addr[1:0] = 2'($urandom_range(1, 3));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
